// File: rtl/mul_issue_scheduler.sv
// Issue gating and writeback-slot reservation for the fixed-latency multiplier.
// Define MUL_ISSUE_SCB_EN to interlock on pending multiply destinations (RAW/WAW).
module mul_issue_scheduler #(
  parameter int MUL_LAT = 5,
  parameter int ALU_LAT = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           iss_valid_i,
  input  logic                           iss_is_m_i,
  input  logic [4:0]                     iss_rd_i,
  input  logic [4:0]                     iss_rs1_i,
  input  logic [4:0]                     iss_rs2_i,
  input  logic                           iss_rs1_used_i,
  input  logic                           iss_rs2_used_i,
  output logic                           iss_ready_o,
  output logic                           mul_fire_o,
  output logic                           alu_fire_o,
  input  logic                           stall_pipe_i,
  input  logic                           kill_i,
  output logic                           stall_mul_o,
  output logic                           kill_mul_o,
  output logic                           wb_sel_mul_o,
  output logic [4:0]                     wb_rd_o,
  output logic [$clog2(MUL_LAT+1)-1:0]   inflight_cnt_o,
  output logic                           busy_o
);
  localparam int CW = $clog2(MUL_LAT+1);

  // occ[j]: a multiply writes back j cycles from now; rdq[j] is its destination
  logic [MUL_LAT-1:0]      occ;
  logic [MUL_LAT-1:0][4:0] rdq;
  logic                    raw_hazard;

`ifdef MUL_ISSUE_SCB_EN
  // Slot 0 is excluded: its result is on the writeback bypass this cycle
  always_comb begin
    raw_hazard = 1'b0;
    for (int j = 1; j < MUL_LAT; j++) begin
      if (occ[j] && rdq[j] != 5'd0) begin
        if ((iss_rs1_used_i && iss_rs1_i == rdq[j]) ||
            (iss_rs2_used_i && iss_rs2_i == rdq[j]))
          raw_hazard = 1'b1;
        if (j >= ALU_LAT && iss_rd_i == rdq[j])
          raw_hazard = 1'b1;
      end
    end
  end
`else
  logic unused_scb;
  assign unused_scb = ^{iss_rs1_i, iss_rs2_i, iss_rs1_used_i, iss_rs2_used_i};
  assign raw_hazard = 1'b0;
`endif

  assign iss_ready_o = !stall_pipe_i && !kill_i &&
                       !(!iss_is_m_i && occ[ALU_LAT]) && !raw_hazard;
  assign mul_fire_o  = iss_valid_i && iss_ready_o && iss_is_m_i;
  assign alu_fire_o  = iss_valid_i && iss_ready_o && !iss_is_m_i;

  assign stall_mul_o  = stall_pipe_i;
  assign kill_mul_o   = kill_i;
  assign wb_sel_mul_o = occ[0];
  assign wb_rd_o      = occ[0] ? rdq[0] : 5'd0;
  assign busy_o       = |occ;

  always_comb begin
    inflight_cnt_o = '0;
    for (int j = 0; j < MUL_LAT; j++)
      inflight_cnt_o = inflight_cnt_o + {{(CW-1){1'b0}}, occ[j]};
  end

  // Kill wins over stall; a stall freezes the whole reservation vector
  always_ff @(posedge clk) begin
    if (!rst || kill_i) begin
      occ <= '0;
      rdq <= '0;
    end else if (!stall_pipe_i) begin
      occ <= {mul_fire_o, occ[MUL_LAT-1:1]};
      rdq <= {iss_rd_i, rdq[MUL_LAT-1:1]};
    end
  end
endmodule
